// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Run/pause/lap/clear sequencer for the stopwatch. Synchronises
//               and debounces two raw buttons, runs the 4-state FSM and
//               generates the 0.1 s count tick, clear pulse and lap hold flag.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int CLK_HZ          = 125_000_000,
    parameter int TICK_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 1_250_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_lap,
    output logic       run_en,
    output logic       tick,
    output logic       clr,
    output logic       hold,
    output logic [1:0] state,
    output logic       led
);

    localparam int c_div = CLK_HZ / TICK_HZ;
    localparam int c_pw  = $clog2(c_div);
    localparam int c_dw  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_pw-1:0] c_presc_max = c_pw'(c_div - 1);
    localparam logic [c_dw-1:0] c_db_max    = c_dw'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    logic [1:0]      w_raw;
    logic [1:0]      w_press;
    logic            w_run_p;
    logic            w_lap_p;
    logic            w_clear;
    state_t          r_state;
    state_t          w_next;
    logic [c_pw-1:0] r_presc;
    logic            r_tick;
    logic            r_clr;
    logic            r_led;

    assign w_raw = {btn_lap, btn_run};

    // One synchroniser + debouncer + rising-edge detector per button
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic            r_sync1;
        logic            r_sync2;
        logic            r_stable;
        logic            r_stable_d;
        logic            r_press;
        logic [c_dw-1:0] r_cnt;

        // Stable level follows the synced input only after a full run of mismatches
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_sync1    <= 1'b0;
                r_sync2    <= 1'b0;
                r_stable   <= 1'b0;
                r_stable_d <= 1'b0;
                r_press    <= 1'b0;
                r_cnt      <= '0;
            end else begin
                r_sync1    <= w_raw[i];
                r_sync2    <= r_sync1;
                r_stable_d <= r_stable;
                r_press    <= r_stable & ~r_stable_d;
                if (r_sync2 != r_stable) begin
                    if (r_cnt == c_db_max) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_dw'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_press[i] = r_press;
    end

    assign w_run_p = w_press[0];
    assign w_lap_p = w_press[1];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; run press takes priority over a simultaneous lap press
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_run_p) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_run_p)      w_next = S_PAUSE;
                else if (w_lap_p) w_next = S_LAP;
            end
            S_LAP: begin
                if (w_run_p)      w_next = S_PAUSE;
                else if (w_lap_p) w_next = S_RUN;
            end
            S_PAUSE: begin
                if (w_run_p) begin
                    w_next = S_RUN;
                end else if (w_lap_p) begin
                    w_next  = S_IDLE;
                    w_clear = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign run_en = (r_state == S_RUN) || (r_state == S_LAP);
    assign hold   = (r_state == S_LAP);

    // Prescaler, tick, led and clear pulse; a tick scheduled at RUN->PAUSE is still emitted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_clr   <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            r_clr  <= w_clear;
            r_tick <= run_en && (r_presc == c_presc_max);
            if (w_clear) begin
                r_presc <= '0;
                r_led   <= 1'b0;
            end else if (run_en) begin
                if (r_presc == c_presc_max) begin
                    r_presc <= '0;
                    r_led   <= ~r_led;
                end else begin
                    r_presc <= r_presc + c_pw'(1);
                end
            end
        end
    end

    assign tick  = r_tick;
    assign clr   = r_clr;
    assign led   = r_led;
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Self-checking bench for stopwatch_ctrl (DIV=10, debounce 4)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_lap = 1'b0;
    logic       run_en;
    logic       tick;
    logic       clr;
    logic       hold;
    logic [1:0] state;
    logic       led;

    stopwatch_ctrl #(
        .CLK_HZ         (100),
        .TICK_HZ        (10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .btn_run(btn_run),
        .btn_lap(btn_lap),
        .run_en (run_en),
        .tick   (tick),
        .clr    (clr),
        .hold   (hold),
        .state  (state),
        .led    (led)
    );

    always #5 clock = ~clock;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model of prescaler/tick/led, stepped once per cycle
    bit pend       = 1'b0;
    int pc         = 0;
    bit led_m      = 1'b0;
    int en_cnt     = 0;
    int tick_cnt   = 0;
    int clr_pulses = 0;

    always @(negedge clock) begin
        if (reset) begin
            pend     = 1'b0;
            pc       = 0;
            led_m    = 1'b0;
            en_cnt   = 0;
            tick_cnt = 0;
        end else begin
            if (pend) led_m = ~led_m;
            if (clr) begin
                clr_pulses++;
                pc       = 0;
                led_m    = 1'b0;
                en_cnt   = 0;
                tick_cnt = 0;
            end
            check("tick", int'(tick), int'(pend));
            check("led", int'(led), int'(led_m));
            if (tick) tick_cnt++;
            pend = run_en && (pc == 9);
            if (run_en) begin
                en_cnt++;
                pc = (pc == 9) ? 0 : pc + 1;
            end
        end
    end

    typedef struct {
        logic       run;
        logic       lap;
        int         len;
        logic [1:0] st;
        logic       hld;
        logic       en;
        int         clrs;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                run   lap   len st     hold  en    clr
        vecs[0]  = '{1'b0, 1'b1, 8, 2'b11, 1'b1, 1'b1, 0}; // RUN  -> LAP
        vecs[1]  = '{1'b0, 1'b1, 8, 2'b01, 1'b0, 1'b1, 0}; // LAP  -> RUN
        vecs[2]  = '{1'b0, 1'b1, 8, 2'b11, 1'b1, 1'b1, 0}; // RUN  -> LAP
        vecs[3]  = '{1'b1, 1'b0, 8, 2'b10, 1'b0, 1'b0, 0}; // LAP  -> PAUSE
        vecs[4]  = '{1'b1, 1'b0, 8, 2'b01, 1'b0, 1'b1, 0}; // PAUSE-> RUN
        vecs[5]  = '{1'b1, 1'b0, 3, 2'b01, 1'b0, 1'b1, 0}; // 3-cycle glitch ignored
        vecs[6]  = '{1'b1, 1'b0, 4, 2'b10, 1'b0, 1'b0, 0}; // 4-cycle hold accepted
        vecs[7]  = '{1'b1, 1'b0, 8, 2'b01, 1'b0, 1'b1, 0}; // PAUSE-> RUN
        vecs[8]  = '{1'b1, 1'b1, 8, 2'b10, 1'b0, 1'b0, 0}; // both: run wins
        vecs[9]  = '{1'b0, 1'b1, 8, 2'b00, 1'b0, 1'b0, 1}; // PAUSE-> IDLE + clr
        vecs[10] = '{1'b0, 1'b1, 8, 2'b00, 1'b0, 1'b0, 0}; // lap ignored in IDLE
        vecs[11] = '{1'b1, 1'b0, 8, 2'b01, 1'b0, 1'b1, 0}; // IDLE -> RUN
        vecs[12] = '{1'b1, 1'b0, 8, 2'b10, 1'b0, 1'b0, 0}; // RUN  -> PAUSE

        // Reset then idle
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (50) @(posedge clock);
        #1;
        check("idle_state", int'(state), 0);
        check("idle_run_en", int'(run_en), 0);
        check("idle_hold", int'(hold), 0);
        check("idle_clr", int'(clr), 0);
        check("idle_ticks", tick_cnt, 0);

        // Press latency: raw high before edge 0, state changes on edge 7
        btn_run = 1'b1;
        repeat (7) @(posedge clock);
        #1 check("latency_edge6", int'(state), 0);
        @(posedge clock);
        #1 check("latency_edge7", int'(state), 1);
        repeat (9) @(posedge clock);
        #1 check("first_tick_early", int'(tick), 0);
        @(posedge clock);
        #1 check("first_tick", int'(tick), 1);
        check("first_led", int'(led), 1);
        btn_run = 1'b0;
        repeat (12) @(posedge clock);

        // Table-driven button sequences
        for (int i = 0; i < 13; i++) begin
            #1;
            clr_pulses = 0;
            btn_run = vecs[i].run;
            btn_lap = vecs[i].lap;
            repeat (vecs[i].len) @(posedge clock);
            #1;
            btn_run = 1'b0;
            btn_lap = 1'b0;
            repeat (12) @(posedge clock);
            #1;
            check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].st));
            check($sformatf("vec%0d_hold", i), int'(hold), int'(vecs[i].hld));
            check($sformatf("vec%0d_run_en", i), int'(run_en), int'(vecs[i].en));
            check($sformatf("vec%0d_clr", i), clr_pulses, vecs[i].clrs);
        end

        // Paused: every enabled cycle is accounted for by ticks
        check("tick_ratio", tick_cnt, en_cnt / 10);

        // Resume, then assert reset asynchronously mid-RUN
        btn_run = 1'b1;
        repeat (8) @(posedge clock);
        #1 btn_run = 1'b0;
        repeat (17) @(posedge clock);
        #1 check("resume_state", int'(state), 1);
        clr_pulses = 0;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_state", int'(state), 0);
        check("async_reset_run_en", int'(run_en), 0);
        check("async_reset_tick", int'(tick), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("post_reset_state", int'(state), 0);
        check("post_reset_clr", clr_pulses, 0);
        check("post_reset_led", int'(led), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
